// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter and sequencer for one shared combinational ALU.
// Latency: accept edge T -> resp valid from cycle T+1+SETTLE_CYCLES; one transaction at a time.
// Backpressure: req ready only in IDLE for the winner; response held until the granted resp ready.
module alu_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_f,
    output logic        resp_zf,
    output logic        resp_of,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        busy,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [31:0] resp_f_q, resp_f_d;
    logic        resp_zf_q, resp_zf_d;
    logic        resp_of_q, resp_of_d;
    logic        resp0_valid_q, resp0_valid_d;
    logic        resp1_valid_q, resp1_valid_d;
    logic [15:0] done_count_q, done_count_d;

    logic any_req;
    logic winner;
    logic resp_ack;

    // Round-robin only matters on a tie; a lone requester always wins.
    assign any_req  = req0_valid | req1_valid;
    assign winner   = (req0_valid & req1_valid) ? ~last_grant_q : ~req0_valid;
    assign resp_ack = grant_q ? resp1_ready : resp0_ready;

    assign req0_ready = (state_q == IDLE) & any_req & ~winner;
    assign req1_ready = (state_q == IDLE) & any_req &  winner;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        resp_f_d      = resp_f_q;
        resp_zf_d     = resp_zf_q;
        resp_of_d     = resp_of_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        done_count_d  = done_count_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d  = winner;
                    alu_op_d = winner ? req1_op : req0_op;
                    alu_a_d  = winner ? req1_a  : req0_a;
                    alu_b_d  = winner ? req1_b  : req0_b;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_f_d      = alu_f;
                    resp_zf_d     = alu_zf;
                    resp_of_d     = alu_of;
                    resp0_valid_d = ~grant_q;
                    resp1_valid_d = grant_q;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ack) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    done_count_d  = done_count_q + 16'd1;
                    last_grant_d  = grant_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= 4'd0;
            alu_op_q      <= 3'd0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            resp_f_q      <= 32'd0;
            resp_zf_q     <= 1'b0;
            resp_of_q     <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            done_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            resp_f_q      <= resp_f_d;
            resp_zf_q     <= resp_zf_d;
            resp_of_q     <= resp_of_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            done_count_q  <= done_count_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp_f      = resp_f_q;
    assign resp_zf     = resp_zf_q;
    assign resp_of     = resp_of_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed vector table, random traffic against a reference model,
// reset mid-transaction and a slow-settling ALU on a SETTLE_CYCLES=3 instance.
module tb_alu_share_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic rst;

    // Instance with SETTLE_CYCLES = 1
    logic        r0v, r0rdy, r1v, r1rdy, s0v, s0rdy, s1v, s1rdy, rzf, rof, azf, aof, busy;
    logic [2:0]  r0op, r1op, aop;
    logic [31:0] r0a, r0b, r1a, r1b, rf, aa, ab, af;
    logic [15:0] dcnt;

    // Instance with SETTLE_CYCLES = 3
    logic        q_r0v, q_r0rdy, q_r1v, q_r1rdy, q_s0v, q_s0rdy, q_s1v, q_s1rdy;
    logic        q_rzf, q_rof, q_azf, q_aof, q_busy;
    logic [2:0]  q_r0op, q_r1op, q_aop;
    logic [31:0] q_r0a, q_r0b, q_r1a, q_r1b, q_rf, q_aa, q_ab, q_af;
    logic [15:0] q_dcnt;

    int checks = 0;
    int errors = 0;
    int lg_m   = 1;
    int dc_m   = 0;

    // Reference ALU: {of, zf, f}
    function automatic logic [33:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic        of;
        of = 1'b0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
            3'd5: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
            3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = a << b[4:0];
        endcase
        return {of, (f == 32'd0), f};
    endfunction

    assign {aof, azf, af} = alu_ref(aop, aa, ab);

    // Slow ALU: outputs are inverted garbage until its operands have been applied for 3 cycles.
    int          age3;
    logic [33:0] alu3;
    always @(posedge clock or negedge rst) begin
        if (!rst) age3 <= 7;
        else if ((q_r0v && q_r0rdy) || (q_r1v && q_r1rdy)) age3 <= 0;
        else if (age3 < 7) age3 <= age3 + 1;
    end
    assign alu3  = alu_ref(q_aop, q_aa, q_ab);
    assign q_af  = (age3 >= 2) ? alu3[31:0] : ~alu3[31:0];
    assign q_azf = (age3 >= 2) ? alu3[32] : ~alu3[32];
    assign q_aof = (age3 >= 2) ? alu3[33] : ~alu3[33];

    alu_share_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clock(clock), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
        .resp0_valid(s0v), .resp0_ready(s0rdy), .resp1_valid(s1v), .resp1_ready(s1rdy),
        .resp_f(rf), .resp_zf(rzf), .resp_of(rof),
        .alu_op(aop), .alu_a(aa), .alu_b(ab), .alu_f(af), .alu_zf(azf), .alu_of(aof),
        .busy(busy), .done_count(dcnt)
    );

    alu_share_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clock(clock), .rst(rst),
        .req0_valid(q_r0v), .req0_ready(q_r0rdy), .req0_op(q_r0op), .req0_a(q_r0a), .req0_b(q_r0b),
        .req1_valid(q_r1v), .req1_ready(q_r1rdy), .req1_op(q_r1op), .req1_a(q_r1a), .req1_b(q_r1b),
        .resp0_valid(q_s0v), .resp0_ready(q_s0rdy), .resp1_valid(q_s1v), .resp1_ready(q_s1rdy),
        .resp_f(q_rf), .resp_zf(q_rzf), .resp_of(q_rof),
        .alu_op(q_aop), .alu_a(q_aa), .alu_b(q_ab), .alu_f(q_af), .alu_zf(q_azf), .alu_of(q_aof),
        .busy(q_busy), .done_count(q_dcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full transaction on the SETTLE_CYCLES=1 instance; w is the expected winner.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int hold, input logic w,
                           input logic [31:0] ef, input logic ezf, input logic eof);
        @(negedge clock);
        r0v = v0; r0op = op0; r0a = a0; r0b = b0;
        r1v = v1; r1op = op1; r1a = a1; r1b = b1;
        s0rdy = 1'b1; s1rdy = 1'b1;   // resp ready with no resp valid must be ignored
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_grant", {r1rdy, r0rdy}, w ? 2'b10 : 2'b01);
        chk("idle_resp_valid", {s1v, s0v}, 0);
        @(negedge clock);             // first EXEC cycle
        if (w) s1rdy = 1'b0; else s0rdy = 1'b0;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_ready", {r1rdy, r0rdy}, 0);
        chk("exec_resp_valid", {s1v, s0v}, 0);
        chk("exec_alu_op", aop, w ? op1 : op0);
        chk("exec_alu_ab", {aa, ab}, w ? {a1, b1} : {a0, b0});
        @(negedge clock); #1;         // T+2: response
        chk("resp_valid", {s1v, s0v}, w ? 2'b10 : 2'b01);
        chk("resp_f", rf, ef);
        chk("resp_flags", {rzf, rof}, {ezf, eof});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock); #1;
            chk("hold_valid", {s1v, s0v}, w ? 2'b10 : 2'b01);
            chk("hold_resp", {rf, rzf, rof}, {ef, ezf, eof});
            chk("hold_alu", {aop, aa, ab}, w ? {op1, a1, b1} : {op0, a0, b0});
            chk("hold_req_ready", {r1rdy, r0rdy}, 0);
            chk("hold_busy", busy, 1);
        end
        @(negedge clock);
        s0rdy = 1'b1; s1rdy = 1'b1;
        #1;
        chk("ack_valid", {s1v, s0v}, w ? 2'b10 : 2'b01);
        @(negedge clock); #1;
        dc_m++;
        lg_m = w;
        chk("done_valid", {s1v, s0v}, 0);
        chk("done_busy", busy, 0);
        chk("done_count", dcnt, dc_m[15:0]);
        r0v = 1'b0; r1v = 1'b0; s0rdy = 1'b0; s1rdy = 1'b0;
    endtask

    typedef struct {
        logic        v0, v1;
        logic [2:0]  op0;
        logic [31:0] a0, b0;
        logic [2:0]  op1;
        logic [31:0] a1, b1;
        int          hold;
        logic        w;
        logic [31:0] f;
        logic        zf, of;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic        v0, v1, w;
        logic [2:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic [33:0] exp;
        logic [31:0] corner[5];

        tbl[0] = '{1'b1, 1'b1, 3'd0, 32'h12345678, 32'h33332222, 3'd1, 32'h0F0F0000, 32'h000000F0, 0, 1'b0, 32'h12300220, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 3'd0, 32'h12345678, 32'h33332222, 3'd1, 32'h0F0F0000, 32'h000000F0, 0, 1'b1, 32'h0F0F00F0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 3'd4, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'd2, 32'hFFFF0000, 32'h0000FFFF, 2, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 3'd5, 32'h80000000, 32'h80000000, 5, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 3'd6, 32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h0, 32'h0, 0, 1'b0, 32'h00000001, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 3'd7, 32'h00000001, 32'h00000024, 1, 1'b1, 32'h00000010, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 3'd3, 32'h00000000, 32'h00000000, 3'd7, 32'h1, 32'h1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 3'd3, 32'h00000000, 32'h00000000, 3'd5, 32'h80000000, 32'h00000001, 3, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};

        corner[0] = 32'h00000000; corner[1] = 32'h7FFFFFFF; corner[2] = 32'h80000000;
        corner[3] = 32'hFFFFFFFF; corner[4] = 32'h00000001;

        rst = 1'b0;
        r0v = 1'b0; r0op = 3'd0; r0a = 32'd0; r0b = 32'd0;
        r1v = 1'b0; r1op = 3'd0; r1a = 32'd0; r1b = 32'd0;
        s0rdy = 1'b0; s1rdy = 1'b0;
        q_r0v = 1'b0; q_r0op = 3'd0; q_r0a = 32'd0; q_r0b = 32'd0;
        q_r1v = 1'b0; q_r1op = 3'd0; q_r1a = 32'd0; q_r1b = 32'd0;
        q_s0rdy = 1'b0; q_s1rdy = 1'b0;
        #12;
        chk("reset_outputs", {busy, s1v, s0v, rf, rzf, rof, aop, aa, ab, dcnt} == 0, 1);
        chk("reset_ready", {r1rdy, r0rdy}, 0);
        chk("reset_outputs3", {q_busy, q_s1v, q_s0v, q_rf, q_aop, q_aa, q_dcnt} == 0, 1);
        @(negedge clock);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].v0, tbl[i].v1, tbl[i].op0, tbl[i].a0, tbl[i].b0,
                    tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].hold, tbl[i].w,
                    tbl[i].f, tbl[i].zf, tbl[i].of);

        // Reset while in EXEC: transaction discarded, counters and arbitration restart.
        @(negedge clock);
        r1v = 1'b1; r1op = 3'd2; r1a = 32'hDEADBEEF; r1b = 32'h12345678;
        #1;
        chk("rst_test_grant", {r1rdy, r0rdy}, 2'b10);
        @(negedge clock);
        r1v = 1'b0;
        #1;
        chk("rst_test_in_exec", busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_resp", {s1v, s0v, rf, rzf, rof}, 0);
        chk("rst_async_alu", {aop, aa, ab}, 0);
        chk("rst_async_count", dcnt, 0);
        @(negedge clock);
        rst = 1'b1;
        lg_m = 1; dc_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            chk("rst_no_stale", {busy, s1v, s0v}, 0);
        end
        run_txn(1'b1, 1'b1, 3'd2, 32'hA5A5A5A5, 32'hFFFF0000, 3'd0, 32'h1, 32'h1, 0, 1'b0,
                32'h5A5AA5A5, 1'b0, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            a0  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            w   = (v0 && v1) ? (lg_m == 0) : v1;
            exp = w ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
            run_txn(v0, v1, op0, a0, b0, op1, a1, b1, $urandom_range(0, 3), w,
                    exp[31:0], exp[32], exp[33]);
        end

        // SETTLE_CYCLES=3: response at T+4 with values captured after the third EXEC cycle.
        @(negedge clock);
        q_r0v = 1'b1; q_r0op = 3'd4; q_r0a = 32'd5; q_r0b = 32'd7;
        #1;
        chk("s3_grant0", {q_r1rdy, q_r0rdy}, 2'b01);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            q_r0v = 1'b0;
            #1;
            chk("s3_wait_valid", {q_s1v, q_s0v}, 0);
            chk("s3_wait_busy", q_busy, 1);
        end
        @(negedge clock); #1;
        chk("s3_valid0", {q_s1v, q_s0v}, 2'b01);
        chk("s3_f0", q_rf, 32'd12);
        chk("s3_flags0", {q_rzf, q_rof}, 2'b00);
        q_s0rdy = 1'b1;
        @(negedge clock); #1;
        q_s0rdy = 1'b0;
        chk("s3_done0", {q_s1v, q_s0v, q_busy, q_dcnt}, 19'd1);

        @(negedge clock);
        q_r1v = 1'b1; q_r1op = 3'd5; q_r1a = 32'd9; q_r1b = 32'd9;
        #1;
        chk("s3_grant1", {q_r1rdy, q_r0rdy}, 2'b10);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            q_r1v = 1'b0;
            #1;
            chk("s3_wait_valid1", {q_s1v, q_s0v}, 0);
        end
        @(negedge clock); #1;
        chk("s3_valid1", {q_s1v, q_s0v}, 2'b10);
        chk("s3_resp1", {q_rf, q_rzf, q_rof}, {32'd0, 1'b1, 1'b0});
        q_s1rdy = 1'b1;
        @(negedge clock); #1;
        q_s1rdy = 1'b0;
        chk("s3_done1", {q_s1v, q_s0v, q_busy, q_dcnt}, 19'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
